// File: rtl/jtag_shift_engine.sv
// JTAG shift sequencer: turns a 1..DATA_WIDTH bit TMS/TDI command into TCK pulses
// at a programmable rate and returns the captured TDO word on a valid/ready channel.
module jtag_shift_engine #(
   parameter int DIV_WIDTH  = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIV_WIDTH-1:0]          cfg_div,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [$clog2(DATA_WIDTH)-1:0] cmd_len,
   input  logic [DATA_WIDTH-1:0]         cmd_tms,
   input  logic [DATA_WIDTH-1:0]         cmd_tdi,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_tdo,
   output logic                          tck,
   output logic                          tms,
   output logic                          tdi,
   input  logic                          tdo,
   output logic                          busy
);

   localparam int LenWidth = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} stateType;

   stateType              state;
   stateType              stateNext;
   logic                  accept;
   logic                  halfDone;
   logic                  lastBit;
   logic [DATA_WIDTH-1:0] tmsVec;
   logic [DATA_WIDTH-1:0] tdiVec;
   logic [DATA_WIDTH-1:0] tdoVec;
   logic [LenWidth-1:0]   lenReg;
   logic [LenWidth-1:0]   idx;
   logic [LenWidth-1:0]   idxInc;
   logic [DIV_WIDTH-1:0]  divReg;
   logic [DIV_WIDTH-1:0]  cnt;
   logic                  tckQ;
   logic                  tmsQ;
   logic                  tdiQ;
   logic                  readyQ;
   logic                  validQ;
   logic                  busyQ;

   assign halfDone = (cnt == '0);
   assign lastBit  = (idx == lenReg);
   assign idxInc   = idx + LenWidth'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               stateNext = LOW;
            end
         end
         LOW: begin
            if (halfDone) begin
               stateNext = HIGH;
            end
         end
         HIGH: begin
            if (halfDone) begin
               stateNext = lastBit ? RESP : LOW;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Command latch, half-period counter and TDO capture. TMS/TDI only move on
   // the edge that enters LOW, so they are stable for the whole TCK-high phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmsVec <= '0;
         tdiVec <= '0;
         tdoVec <= '0;
         lenReg <= '0;
         idx    <= '0;
         divReg <= '0;
         cnt    <= '0;
         tmsQ   <= 1'b1;
         tdiQ   <= 1'b0;
      end else begin
         if (accept) begin
            tmsVec <= cmd_tms;
            tdiVec <= cmd_tdi;
            tdoVec <= '0;
            lenReg <= cmd_len;
            idx    <= '0;
            divReg <= cfg_div;
            cnt    <= cfg_div;
            tmsQ   <= cmd_tms[0];
            tdiQ   <= cmd_tdi[0];
         end else if (state == LOW) begin
            cnt <= halfDone ? divReg : cnt - DIV_WIDTH'(1);
         end else if (state == HIGH) begin
            if (halfDone) begin
               cnt         <= divReg;
               tdoVec[idx] <= tdo;
               if (!lastBit) begin
                  idx  <= idxInc;
                  tmsQ <= tmsVec[idxInc];
                  tdiQ <= tdiVec[idxInc];
               end
            end else begin
               cnt <= cnt - DIV_WIDTH'(1);
            end
         end
      end
   end

   // Status and TCK are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tckQ   <= 1'b0;
         readyQ <= 1'b1;
         validQ <= 1'b0;
         busyQ  <= 1'b0;
      end else begin
         tckQ   <= (stateNext == HIGH);
         readyQ <= (stateNext == IDLE);
         validQ <= (stateNext == RESP);
         busyQ  <= (stateNext != IDLE);
      end
   end

   assign tck       = tckQ;
   assign tms       = tmsQ;
   assign tdi       = tdiQ;
   assign cmd_ready = readyQ;
   assign rsp_valid = validQ;
   assign busy      = busyQ;
   assign rsp_tdo   = tdoVec;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine: reset TAP, loopback, divider, backpressure,
// partial TDO and reset mid-shift, with per-cycle TCK/TMS/TDI timing checks.
module tb_jtag_shift_engine;

   logic        clk;
   logic        reset;
   logic [7:0]  cfg_div;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_len;
   logic [31:0] cmd_tms;
   logic [31:0] cmd_tdi;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_tdo;
   logic        tck;
   logic        tms;
   logic        tdi;
   logic        tdo;
   logic        busy;
   logic        loopMode;
   logic        tdoVal;

   int errors = 0;
   int checks = 0;

   assign tdo = loopMode ? tdi : tdoVal;

   jtag_shift_engine #(.DIV_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .cfg_div(cfg_div),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
      .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents one command at a negedge and returns #1 after its accept edge.
   task automatic applyStimulus(input logic [7:0] div, input logic [4:0] len,
                                input logic [31:0] tmsV, input logic [31:0] tdiV);
      @(negedge clk);
      checkOutput("ready_before_accept", cmd_ready, 1'b1);
      cfg_div   = div;
      cmd_len   = len;
      cmd_tms   = tmsV;
      cmd_tdi   = tdiV;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Walks every cycle of a shift from just after the accept edge to the response.
   task automatic checkShift(input int div, input int len, input logic [31:0] tmsV,
                             input logic [31:0] tdiV, input logic [31:0] expTdo);
      int h;
      int total;
      int k;
      h     = div + 1;
      total = 2 * h * (len + 1);
      for (int j = 0; j < total; j++) begin
         k = j / (2 * h);
         if (j > 0) begin
            @(posedge clk);
            #1;
         end
         checkOutput("shift_tck", tck, ((j % (2 * h)) >= h) ? 1'b1 : 1'b0);
         checkOutput("shift_tms", tms, tmsV[k]);
         checkOutput("shift_tdi", tdi, tdiV[k]);
         checkOutput("shift_rsp_valid_low", rsp_valid, 1'b0);
         checkOutput("shift_busy", busy, 1'b1);
         checkOutput("shift_ready_low", cmd_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      checkOutput("resp_valid", rsp_valid, 1'b1);
      checkOutput("resp_tck", tck, 1'b0);
      checkOutput("resp_tms_hold", tms, tmsV[len]);
      checkOutput("resp_tdi_hold", tdi, tdiV[len]);
      checkOutput("resp_tdo", rsp_tdo, expTdo);
   endtask

   task automatic finishResp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput("hs_valid_low", rsp_valid, 1'b0);
      checkOutput("hs_ready_high", cmd_ready, 1'b1);
      checkOutput("hs_busy_low", busy, 1'b0);
   endtask

   initial begin
      logic [31:0] heldTdo;
      reset     = 1'b1;
      cfg_div   = '0;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_tms   = '0;
      cmd_tdi   = '0;
      rsp_ready = 1'b0;
      loopMode  = 1'b0;
      tdoVal    = 1'b0;
      #1;
      checkOutput("reset_ready", cmd_ready, 1'b1);
      checkOutput("reset_tck", tck, 1'b0);
      checkOutput("reset_tms", tms, 1'b1);
      checkOutput("reset_tdi", tdi, 1'b0);
      checkOutput("reset_valid", rsp_valid, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_tdo_word", rsp_tdo, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset TAP: five TMS=1 clocks, TDO tied low.
      applyStimulus(8'd0, 5'd4, 32'h0000_001F, 32'h0);
      checkShift(0, 4, 32'h0000_001F, 32'h0, 32'h0);
      finishResp();

      // Loopback of a full 32-bit word.
      loopMode = 1'b1;
      applyStimulus(8'd0, 5'd31, 32'h0, 32'hDEAD_BEEF);
      checkShift(0, 31, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      finishResp();
      loopMode = 1'b0;

      // Divider: H=4, single bit, TDO held high.
      tdoVal = 1'b1;
      applyStimulus(8'd3, 5'd0, 32'h0, 32'h1);
      checkShift(3, 0, 32'h0, 32'h1, 32'h0000_0001);
      finishResp();

      // Partial TDO: 8 bits with TDO high, H=2.
      applyStimulus(8'd1, 5'd7, 32'h0000_0055, 32'h0000_00C3);
      checkShift(1, 7, 32'h0000_0055, 32'h0000_00C3, 32'h0000_00FF);
      finishResp();

      // Backpressure: stall the response with a second command already pending.
      loopMode = 1'b1;
      applyStimulus(8'd0, 5'd2, 32'h0000_0002, 32'h0000_0005);
      checkShift(0, 2, 32'h0000_0002, 32'h0000_0005, 32'h0000_0005);
      loopMode = 1'b0;
      tdoVal   = 1'b1;
      @(negedge clk);
      cfg_div   = 8'd0;
      cmd_len   = 5'd3;
      cmd_tms   = 32'h0000_000A;
      cmd_tdi   = 32'h0000_0006;
      cmd_valid = 1'b1;
      heldTdo   = 32'h0000_0005;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_ready_low", cmd_ready, 1'b0);
         checkOutput("stall_tck", tck, 1'b0);
         checkOutput("stall_valid", rsp_valid, 1'b1);
         checkOutput("stall_tdo_stable", rsp_tdo, heldTdo);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      checkOutput("bp_hs_ready", cmd_ready, 1'b1);
      checkOutput("bp_hs_valid", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checkShift(0, 3, 32'h0000_000A, 32'h0000_0006, 32'h0000_000F);
      finishResp();

      // Reset mid-shift during the TCK-high phase of bit 3 (H=2).
      tdoVal = 1'b0;
      applyStimulus(8'd1, 5'd7, 32'h0000_0000, 32'h0000_00FF);
      repeat (14) @(posedge clk);
      #1;
      checkOutput("mid_tck_high", tck, 1'b1);
      checkOutput("mid_tdi_bit3", tdi, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_tck", tck, 1'b0);
      checkOutput("async_tms", tms, 1'b1);
      checkOutput("async_tdi", tdi, 1'b0);
      checkOutput("async_busy", busy, 1'b0);
      checkOutput("async_valid", rsp_valid, 1'b0);
      checkOutput("async_ready", cmd_ready, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("post_reset_valid", rsp_valid, 1'b0);
      checkOutput("post_reset_ready", cmd_ready, 1'b1);
      checkOutput("post_reset_tck", tck, 1'b0);
      checkOutput("post_reset_tdo_word", rsp_tdo, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jtag_shift_engine.md
# jtag_shift_engine

Hardware JTAG sequencer that replaces GPIO bit-banging of the debug TAP. It accepts shift commands of 1–32 bits, each carrying per-bit TMS and TDI vectors. It generates TCK at a programmable rate, drives TMS/TDI, captures TDO into a response word and returns the response on a valid/ready channel. It sits between the CPU-side command interface and the TCK/TMS/TDI/TDO pins.

## Interface
Parameters:
- DIV_WIDTH, 8, width of the clock-divider field
- DATA_WIDTH, 32, maximum bits per command; LEN field is clog2(DATA_WIDTH) bits

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cfg_div  input  DIV_WIDTH  TCK half-period minus 1, in clk cycles; sampled at command accept
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine idle, command accepted on valid&&ready edge
- cmd_len  input  5  number of bits minus 1 (0 → 1 bit, 31 → 32 bits)
- cmd_tms  input  DATA_WIDTH  TMS per bit, LSB first
- cmd_tdi  input  DATA_WIDTH  TDI per bit, LSB first
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed on valid&&ready edge
- rsp_tdo  output  DATA_WIDTH  captured TDO, bit i = TDO during bit i; bits above cmd_len are 0
- tck  output  1  JTAG clock
- tms  output  1  JTAG mode select
- tdi  output  1  JTAG data to target
- tdo  input  1  JTAG data from target
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, LOW, HIGH, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch tms/tdi vectors, len, and H = cfg_div+1; clear the bit index and rsp_tdo; go to LOW.
- LOW:
  - tck=0; tms/tdi = latched bit[index].
  - After H clk cycles, go to HIGH.
- HIGH:
  - tck=1; tms/tdi unchanged.
  - On the clk edge ending the H-th cycle, sample tdo into rsp_tdo[index].
  - If index==len, go to RESP; otherwise increment index and go to LOW.
- RESP:
  - tck=0; rsp_valid=1; rsp_tdo stable.
  - On rsp_ready, go to IDLE.
- Between commands, tms/tdi hold the last driven bit values and tck stays 0. TAP state therefore cannot change.
- cmd_valid outside IDLE is ignored; command inputs are not sampled.
- Half-period counter is DIV_WIDTH bits and counts down from cfg_div. cfg_div=0 gives H=1, TCK = clk/2. cfg_div=255 gives H=256.
- Reset (async, any state) forces:
  - state=IDLE, cmd_ready=1
  - tck=0, tms=1, tdi=0
  - rsp_valid=0, rsp_tdo=0, busy=0
  
  Reset mid-shift aborts the shift with no response produced.

## Timing
- Accept edge E0. tck rises after edge E(H) and falls after edge E(2H); bit k spans E(2Hk)..E(2H(k+1)).
- TDO bit k is sampled at edge E(2H(k+1)), the last cycle before TCK falls.
- N = len+1 bits: rsp_valid rises after edge E(2HN). Command-to-response latency is 2HN clk cycles.
- cmd_ready rises the cycle after the response handshake edge. Back-to-back command throughput is therefore 2HN+2 cycles minimum with rsp_ready held high.
- tms/tdi change only on the clk edge that enters LOW, i.e. while tck=0. They never change while tck=1.
- All outputs are registered; none combinationally depends on an input.

## Test plan
- Reset TAP: cfg_div=0, cmd_len=4, cmd_tms=0x1F, cmd_tdi=0
  - Expect 5 TCK pulses, each 1 clk high / 1 clk low, with tms=1 throughout.
  - Expect rsp_valid 10 cycles after accept and rsp_tdo=0 (tdo tied 0).
- Loopback: tdo wired to tdi, cfg_div=0, cmd_len=31, cmd_tdi=0xDEADBEEF, cmd_tms=0 → rsp_tdo=0xDEADBEEF; last tdi=1.
- Divider: cfg_div=3, cmd_len=0, cmd_tdi=1, tdo held 1
  - Expect tck low 4 cycles then high 4 cycles.
  - Expect rsp_valid after 8 cycles and rsp_tdo=0x00000001.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid, and assert cmd_valid throughout
  - Expect cmd_ready=0, tck=0, and rsp_tdo constant during the stall.
  - Expect the second command to be accepted one cycle after the handshake.
- Partial TDO: cmd_len=7, tdo held 1 → rsp_tdo=0x000000FF.
- Reset mid-shift: assert reset during HIGH of bit 3
  - Expect outputs to take reset values immediately, without waiting for a clk edge: tck=0, tms=1, tdi=0, busy=0, rsp_valid=0.
  - Expect no response after release and cmd_ready=1.
